lif_array: RTL and testbench
============================

LIF_ARRAY -- requirements
Module: lif_array

Interface
REQ-001 Parameter: N_CH, default 4, number of independent neuron channels (1..16).
REQ-002 Parameter: W, default 8, membrane, current and threshold width in bits (4..16).
REQ-003 Parameter: THR_INIT, default 127, reset and minimum threshold.
REQ-004 Parameter: BETA_SHIFT, default 3, reset leak shift and maximum leak shift (1..7).
REQ-005 Parameter: REFRAC_CYC, default 2, refractory length in steps (1..15).
REQ-006 Port: clk  in  1  clock; all logic is on the rising edge.
REQ-007 Port: rst  in  1  reset; synchronous and active-high.
REQ-008 Port: step  in  1  advances every channel one timestep in this cycle.
REQ-009 Port: current  in  N_CH*W  unsigned input currents; channel k occupies bits [k*W +: W].
REQ-010 Port: learn_thr  in  1  enables adaptive threshold.
REQ-011 Port: learn_beta  in  1  enables adaptive leak.
REQ-012 Port: sel  in  max(1,clog2(N_CH))  selects the channel shown on state_out.
REQ-013 Port: state_out  out  W  registered membrane of channel sel; combinational mux of registers.
REQ-014 Port: spike  out  N_CH  per-channel spike pulse.
REQ-015 Port: spike_cnt  out  16  total spikes since reset.

Function
REQ-016 The block SHALL update channel state only in cycles with step=1; all state SHALL hold when step=0.
REQ-017 The leak SHALL be leaked = mem - (mem >> beta_sh[k]).
REQ-018 The integration SHALL be sum = leaked + current[k], computed at W+1 bits and saturated to 2^W-1.
REQ-019 A channel SHALL spike when sum >= thr[k] and it is not refractory; on a spike, mem SHALL become sum - thr[k], otherwise mem SHALL become sum.
REQ-020 spike[k] SHALL be registered, high for exactly the one cycle after a spiking step cycle, and 0 in all other cycles (latency 1).
REQ-021 When learn_thr=1 at a step, a spike SHALL raise thr[k] by 1, saturating at 2^W-1; a non-spike step SHALL lower thr[k] by 1 when it is above THR_INIT. When learn_thr=0, thr[k] SHALL hold.
REQ-022 When learn_beta=1 at a step, a spike SHALL decrement beta_sh[k] (floor 1); a non-spike step SHALL increment it when below BETA_SHIFT. When learn_beta=0, beta_sh[k] SHALL hold.
REQ-023 The comparison SHALL use the pre-update thr[k]; the learn inputs SHALL be sampled only in step cycles.
REQ-024 spike_cnt SHALL add the popcount of the spiking channels each step and saturate at 0xFFFF.
REQ-025 Channels SHALL be fully independent; simultaneous spikes on all channels SHALL be counted correctly.

Reset
REQ-026 rst SHALL take priority over step, including mid-operation.
REQ-027 On rst, the block SHALL set: mem=0, thr=THR_INIT, beta_sh=BETA_SHIFT, refractory counters=0, spike=0, spike_cnt=0.
REQ-028 state_out SHALL read 0 in the cycle after reset.

Configuration
REQ-029 With LIF_REFRACTORY_EN defined:
- a spike SHALL load the channel's refractory counter with REFRAC_CYC.
- while the counter is nonzero, a step SHALL apply leak only (current ignored, no spike, no learning) and decrement the counter.
REQ-030 Without LIF_REFRACTORY_EN, the refractory counters SHALL not exist and every step SHALL integrate.

Verification (N_CH=4, W=8, THR_INIT=127, BETA_SHIFT=3, REFRAC_CYC=2)
REQ-031 Scenario: ch0 current=100, two steps -> mem 100 with no spike, then 188 spikes; spike[0] pulses once; mem=61; spike_cnt=1.
REQ-032 Scenario: continue REQ-031 with LIF_REFRACTORY_EN -> the next two steps give mem 54, 48 with no spike. Without the macro, the next step gives 154 -> spike, mem=27.
REQ-033 Scenario: current=255 on all channels, learn_thr=1, one step -> spike=4'b1111, mem=128 each, thr=128 each, spike_cnt=4.
REQ-034 Scenario: learn_beta=1, three spiking steps on ch1 -> beta_sh[1]=1 (floored); then non-spiking steps restore it to 3, one per step.
REQ-035 Scenario: rst asserted in the same cycle as step with nonzero current -> all outputs 0, thr=127, spike_cnt=0.
REQ-036 Scenario: step=0 for 10 cycles with current=255 -> no state change and no spike.

Source files
------------

// File: rtl/lif_array.sv
// Array of independent leaky integrate-and-fire neurons with adaptive threshold and leak.
// Define LIF_REFRACTORY_EN to add a per-channel refractory period after each spike.
module lif_array #(
  parameter int N_CH       = 4,
  parameter int W          = 8,
  parameter int THR_INIT   = 127,
  parameter int BETA_SHIFT = 3,
  parameter int REFRAC_CYC = 2,
  localparam int SW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic [N_CH*W-1:0] current,
  input  logic              learn_thr,
  input  logic              learn_beta,
  input  logic [SW-1:0]     sel,
  output logic [W-1:0]      state_out,
  output logic [N_CH-1:0]   spike,
  output logic [15:0]       spike_cnt
);

  localparam logic [W-1:0] MEM_MAX  = '1;
  localparam logic [W-1:0] THR_RST  = W'(THR_INIT);
  localparam logic [2:0]   BETA_RST = 3'(BETA_SHIFT);

  logic [W-1:0]    mem_q  [N_CH];
  logic [W-1:0]    mem_d  [N_CH];
  logic [W-1:0]    thr_q  [N_CH];
  logic [W-1:0]    thr_d  [N_CH];
  logic [2:0]      beta_q [N_CH];
  logic [2:0]      beta_d [N_CH];
  logic [N_CH-1:0] spike_q;
  logic [15:0]     cnt_q;
  logic [15:0]     cnt_d;

  logic [W-1:0]    leaked  [N_CH];
  logic [W:0]      sum_ext [N_CH];
  logic [W-1:0]    sum_sat [N_CH];
  logic [N_CH-1:0] fire;
  logic [N_CH-1:0] refr;
  logic [4:0]      pop;
  logic [16:0]     cnt_ext;

`ifdef LIF_REFRACTORY_EN
  localparam logic [3:0] REFRAC_LD = 4'(REFRAC_CYC);
  logic [3:0] rcnt_q [N_CH];
  logic [3:0] rcnt_d [N_CH];
`endif

  always_comb begin
    pop  = '0;
    fire = '0;
    refr = '0;
    for (int k = 0; k < N_CH; k++) begin
      leaked[k]  = mem_q[k] - (mem_q[k] >> beta_q[k]);
      sum_ext[k] = {1'b0, leaked[k]} + {1'b0, current[k*W +: W]};
      sum_sat[k] = sum_ext[k][W] ? MEM_MAX : sum_ext[k][W-1:0];
      thr_d[k]   = thr_q[k];
      beta_d[k]  = beta_q[k];
`ifdef LIF_REFRACTORY_EN
      rcnt_d[k]  = rcnt_q[k];
      refr[k]    = (rcnt_q[k] != 4'd0);
`endif
      // The comparison always uses the threshold held before this step.
      fire[k]    = !refr[k] && (sum_sat[k] >= thr_q[k]);
      mem_d[k]   = sum_sat[k];
      if (refr[k]) begin
        // Refractory: leak only, input and learning are ignored.
        mem_d[k] = leaked[k];
`ifdef LIF_REFRACTORY_EN
        rcnt_d[k] = rcnt_q[k] - 4'd1;
`endif
      end else begin
        if (fire[k]) begin
          mem_d[k] = sum_sat[k] - thr_q[k];
`ifdef LIF_REFRACTORY_EN
          rcnt_d[k] = REFRAC_LD;
`endif
        end
        if (learn_thr) begin
          if (fire[k]) begin
            if (thr_q[k] != MEM_MAX) thr_d[k] = thr_q[k] + 1'b1;
          end else if (thr_q[k] > THR_RST) begin
            thr_d[k] = thr_q[k] - 1'b1;
          end
        end
        if (learn_beta) begin
          if (fire[k]) begin
            if (beta_q[k] > 3'd1) beta_d[k] = beta_q[k] - 3'd1;
          end else if (beta_q[k] < BETA_RST) begin
            beta_d[k] = beta_q[k] + 3'd1;
          end
        end
      end
      pop = pop + 5'(fire[k]);
    end
    cnt_ext = {1'b0, cnt_q} + 17'(pop);
    cnt_d   = cnt_ext[16] ? 16'hFFFF : cnt_ext[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        mem_q[k]  <= '0;
        thr_q[k]  <= THR_RST;
        beta_q[k] <= BETA_RST;
`ifdef LIF_REFRACTORY_EN
        rcnt_q[k] <= '0;
`endif
      end
      spike_q <= '0;
      cnt_q   <= '0;
    end else if (step) begin
      for (int k = 0; k < N_CH; k++) begin
        mem_q[k]  <= mem_d[k];
        thr_q[k]  <= thr_d[k];
        beta_q[k] <= beta_d[k];
`ifdef LIF_REFRACTORY_EN
        rcnt_q[k] <= rcnt_d[k];
`endif
      end
      spike_q <= fire;
      cnt_q   <= cnt_d;
    end else begin
      spike_q <= '0;
    end
  end

  always_comb begin
    state_out = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (SW'(k) == sel) state_out = mem_q[k];
    end
  end

  assign spike     = spike_q;
  assign spike_cnt = cnt_q;

endmodule

// File: tb/tb_lif_array.sv
// Directed bench for lif_array at N_CH=4, W=8, THR_INIT=127, BETA_SHIFT=3, REFRAC_CYC=2.
module tb_lif_array;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step = 1'b0;
  logic [31:0] current = '0;
  logic        learn_thr = 1'b0;
  logic        learn_beta = 1'b0;
  logic [1:0]  sel = '0;
  logic [7:0]  state_out;
  logic [3:0]  spike;
  logic [15:0] spike_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  lif_array #(
    .N_CH(4), .W(8), .THR_INIT(127), .BETA_SHIFT(3), .REFRAC_CYC(2)
  ) dut (
    .clk(clk), .rst(rst), .step(step), .current(current),
    .learn_thr(learn_thr), .learn_beta(learn_beta), .sel(sel),
    .state_out(state_out), .spike(spike), .spike_cnt(spike_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stp;
    logic [31:0] cur;
    logic        lt;
    logic        lb;
    logic [1:0]  sel;
    logic [7:0]  mem;
    logic [3:0]  spk;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic [31:0] c,
                     input logic lt, input logic lb, input logic [1:0] sl,
                     input logic [7:0] m, input logic [3:0] sp, input logic [15:0] cn);
    vec_t v;
    v.rst = r; v.stp = s; v.cur = c; v.lt = lt; v.lb = lb; v.sel = sl;
    v.mem = m; v.spk = sp; v.cnt = cn;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  // One clock with the given inputs; rst/step drop again right after the edge.
  task automatic cycle(input logic r, input logic s, input logic [31:0] c,
                       input logic lt, input logic lb);
    rst = r; step = s; current = c; learn_thr = lt; learn_beta = lb;
    @(posedge clk);
    #1;
    rst = 1'b0; step = 1'b0;
  endtask

  localparam logic [31:0] ALL = 32'hFFFF_FFFF;
  localparam logic [31:0] C1F = 32'h0000_FF00;

  initial begin
    // Reset state, observed on every channel.
    add(1, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 4'h0, 0);
    add(0, 0, 0, 0, 0, 2, 0, 4'h0, 0);
    add(0, 0, 0, 0, 0, 3, 0, 4'h0, 0);
    // ch0 current 100.
    add(0, 1, 32'd100, 0, 0, 0, 100, 4'h0, 0);
    add(0, 1, 32'd100, 0, 0, 0,  61, 4'h1, 1);
`ifdef LIF_REFRACTORY_EN
    add(0, 1, 32'd100, 0, 0, 0,  54, 4'h0, 1);
    add(0, 1, 32'd100, 0, 0, 0,  48, 4'h0, 1);
    add(0, 1, 32'd100, 0, 0, 0,  15, 4'h1, 2);
`else
    add(0, 1, 32'd100, 0, 0, 0,  27, 4'h1, 2);
`endif
    add(0, 0, 32'd100, 0, 0, 0, `ifdef LIF_REFRACTORY_EN 15 `else 27 `endif, 4'h0, 2);
    // All channels saturated, threshold learning.
    add(1, 0, 0,   0, 0, 0,   0, 4'h0, 0);
    add(0, 1, ALL, 1, 0, 0, 128, 4'hF, 4);
    add(0, 0, ALL, 0, 0, 1, 128, 4'h0, 4);
    add(0, 0, ALL, 0, 0, 2, 128, 4'h0, 4);
    add(0, 0, ALL, 0, 0, 3, 128, 4'h0, 4);
`ifdef LIF_REFRACTORY_EN
    add(0, 1, 0, 0, 0, 0, 112, 4'h0, 4);
    add(0, 1, 0, 0, 0, 0,  98, 4'h0, 4);
    add(0, 1, 32'd41, 0, 0, 0, 127, 4'h0, 4);
`else
    add(0, 1, 32'd15, 0, 0, 0, 127, 4'h0, 4);
`endif
    // 127 < raised threshold 128; then a learning non-spike step brings it back to 127.
    add(0, 1, 0,      1, 0, 0, 112, 4'h0, 4);
    add(0, 1, 32'd29, 0, 0, 0,   0, 4'h1, 5);
    // Reset coincident with a step, after raising the threshold.
    add(1, 0, 0,   0, 0, 0,   0, 4'h0, 0);
    add(0, 1, ALL, 1, 0, 0, 128, 4'hF, 4);
    add(1, 1, ALL, 1, 1, 0,   0, 4'h0, 0);
    add(0, 0, ALL, 0, 0, 2,   0, 4'h0, 0);
    add(0, 1, 32'd127, 0, 0, 0, 0, 4'h1, 1);
    // Adaptive leak on ch1.
    add(1, 0, 0, 0, 0, 1, 0, 4'h0, 0);
`ifdef LIF_REFRACTORY_EN
    add(0, 1, C1F, 0, 1, 1, 128, 4'h2, 1);
    add(0, 1, C1F, 0, 1, 1,  96, 4'h0, 1);
    add(0, 1, C1F, 0, 1, 1,  72, 4'h0, 1);
    add(0, 1, C1F, 0, 1, 1, 128, 4'h2, 2);
    add(0, 1, C1F, 0, 1, 1,  64, 4'h0, 2);
    add(0, 1, C1F, 0, 1, 1,  32, 4'h0, 2);
    add(0, 1, C1F, 0, 1, 1, 128, 4'h2, 3);
    add(0, 1, 0,   0, 1, 1,  64, 4'h0, 3);
    add(0, 1, 0,   0, 1, 1,  32, 4'h0, 3);
    add(0, 1, 0,   0, 1, 1,  16, 4'h0, 3);
    add(0, 1, 0,   0, 1, 1,  12, 4'h0, 3);
    add(0, 1, 0,   0, 1, 1,  11, 4'h0, 3);
`else
    add(0, 1, C1F, 0, 1, 1, 128, 4'h2, 1);
    add(0, 1, C1F, 0, 1, 1, 128, 4'h2, 2);
    add(0, 1, C1F, 0, 1, 1, 128, 4'h2, 3);
    add(0, 1, 0,   0, 1, 1,  64, 4'h0, 3);
    add(0, 1, 0,   0, 1, 1,  48, 4'h0, 3);
    add(0, 1, 0,   0, 1, 1,  42, 4'h0, 3);
    add(0, 1, 0,   0, 1, 1,  37, 4'h0, 3);
`endif

    @(negedge clk);
    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      cycle(vecs[i].rst, vecs[i].stp, vecs[i].cur, vecs[i].lt, vecs[i].lb);
      check("mem", i, 32'(state_out), 32'(vecs[i].mem));
      check("spike", i, 32'(spike), 32'(vecs[i].spk));
      check("cnt", i, 32'(spike_cnt), 32'(vecs[i].cnt));
    end

    // Idle cycles with large input leave everything untouched.
    sel = 0;
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 32'd100, 0, 0);
    cycle(0, 1, 32'd100, 0, 0);
    check("hold_pre_spike", 0, 32'(spike), 32'h1);
    check("hold_pre_mem", 0, 32'(state_out), 32'd61);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, ALL, 1, 1);
      check("hold_mem", i, 32'(state_out), 32'd61);
      check("hold_spike", i, 32'(spike), 32'h0);
      check("hold_cnt", i, 32'(spike_cnt), 32'd1);
    end
    cycle(0, 1, 0, 0, 0);
    check("hold_resume_mem", 0, 32'(state_out), 32'd54);

    // Spike counter saturation with every channel firing.
    cycle(1, 0, 0, 0, 0);
    current = ALL;
    step = 1'b1;
    repeat (99) @(posedge clk);
    #1;
    step = 1'b0;
`ifdef LIF_REFRACTORY_EN
    check("cnt_mid", 0, 32'(spike_cnt), 32'd132);
`else
    check("cnt_mid", 0, 32'(spike_cnt), 32'd396);
`endif
    step = 1'b1;
`ifdef LIF_REFRACTORY_EN
    repeat (50000) @(posedge clk);
`else
    repeat (17000) @(posedge clk);
`endif
    #1;
    step = 1'b0;
    check("cnt_sat", 0, 32'(spike_cnt), 32'hFFFF);
    cycle(0, 1, ALL, 0, 0);
    check("cnt_sat_hold", 0, 32'(spike_cnt), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
